// File: rtl/exu_mdu_pkg.sv
// mdu_pkg: shared types and op-decode helpers for the iterative multiply/divide unit.
//   mdu_op_e    : RV32M/RV64M funct3 encodings
//   mdu_state_e : sequencer states
//   is_div / is_rem / is_signed_a / is_signed_b : op classification helpers
package mdu_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div(mdu_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_rem(mdu_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

    // rs1 is treated as two's complement
    function automatic logic is_signed_a(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    // rs2 is treated as two's complement (MULHSU takes rs2 unsigned)
    function automatic logic is_signed_b(mdu_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/exu_mdu_step.sv
// exu_mdu_step: one radix-2 iteration of the shared multiply/divide datapath.
// Purely combinational; the top chains UNROLL of these per clock.
//   div_i  : 1 = restoring divide step, 0 = shift-add multiply step
//   acc_i  : 2*XLEN accumulator. Multiply: {partial product hi, remaining multiplier}.
//            Divide: {partial remainder, remaining dividend / quotient bits}.
//   opd_i  : multiplicand (multiply) or divisor (divide), magnitude form
//   acc_o  : next accumulator; in divide mode the LSB is left 0 for the quotient bit
//   bit_o  : quotient bit produced by this step (0 in multiply mode)
module exu_mdu_step #(
    parameter int XLEN = 32
) (
    input  logic              div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   opd_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic              bit_o
);

    logic [XLEN:0] sum;
    logic [XLEN:0] trial;
    logic [XLEN:0] diff;

    always_comb begin
        // multiply: add multiplicand into the high half when the multiplier LSB is set
        sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + {1'b0, (acc_i[0] ? opd_i : {XLEN{1'b0}})};
        // divide: remainder shifted left with the next dividend bit brought in
        trial = acc_i[2*XLEN-1:XLEN-1];
        diff  = trial - {1'b0, opd_i};
        acc_o = '0;
        bit_o = 1'b0;
        if (div_i) begin
            // partial remainder stays below the divisor, so the MSB of diff is a clean borrow
            bit_o = ~diff[XLEN];
            acc_o = {(bit_o ? diff[XLEN-1:0] : trial[XLEN-1:0]), acc_i[XLEN-2:0], 1'b0};
        end else begin
            acc_o = {sum, acc_i[XLEN-1:1]};
        end
    end

endmodule

// File: rtl/exu_mdu.sv
// exu_mdu: iterative RV32M/RV64M multiply/divide unit.
//   clk_i, rst_i (async, active-high), flush_i (sync kill)
//   req_valid_i/req_ready_o, req_op_i (funct3), req_rs1_i, req_rs2_i : request channel
//   rsp_valid_o/rsp_ready_i, rsp_data_o                              : response channel
//   busy_o : sequencer not idle
// Operands are reduced to magnitudes at accept, XLEN/UNROLL iterations run on an
// unsigned datapath, then one more CALC cycle applies sign/half-select and the
// divide special-case override into the response register.
module exu_mdu
    import mdu_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [2:0]      req_op_i,
    input  logic [XLEN-1:0] req_rs1_i,
    input  logic [XLEN-1:0] req_rs2_i,
    output logic            rsp_valid_o,
    input  logic            rsp_ready_i,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            busy_o
);

    localparam int ITER = XLEN / UNROLL;
    localparam int CW   = $clog2(ITER);
    localparam int AW   = 2 * XLEN;

    mdu_state_e      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            fin_q, fin_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [XLEN-1:0] opd_q, opd_d;
    mdu_op_e         op_q, op_d;
    logic            neg_q, neg_d;
    logic            spec_q, spec_d;
    logic [XLEN-1:0] spec_val_q, spec_val_d;
    logic [XLEN-1:0] rsp_data_q, rsp_data_d;

    // ---------------- accept-time operand preparation ----------------
    mdu_op_e         req_op;
    logic            sgn_a, sgn_b, div0, ovf;
    logic [XLEN-1:0] mag_a, mag_b;

    always_comb begin
        req_op = mdu_op_e'(req_op_i);
        sgn_a  = is_signed_a(req_op) & req_rs1_i[XLEN-1];
        sgn_b  = is_signed_b(req_op) & req_rs2_i[XLEN-1];
        // -2^(XLEN-1) negates to itself, which is the correct unsigned magnitude
        mag_a  = sgn_a ? -req_rs1_i : req_rs1_i;
        mag_b  = sgn_b ? -req_rs2_i : req_rs2_i;
        div0   = (req_rs2_i == '0);
        ovf    = is_signed_b(req_op) && is_div(req_op) &&
                 (req_rs1_i == {1'b1, {(XLEN-1){1'b0}}}) && (&req_rs2_i);
    end

    // ---------------- iteration chain ----------------
    logic [UNROLL:0][AW-1:0]   chain;
    logic [UNROLL-1:0][AW-1:0] step_acc;
    logic [UNROLL-1:0]         step_bit;
    logic                      div_mode;

    assign div_mode = is_div(op_q);
    assign chain[0] = acc_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_step
        exu_mdu_step #(.XLEN(XLEN)) u_step (
            .div_i (div_mode),
            .acc_i (chain[g]),
            .opd_i (opd_q),
            .acc_o (step_acc[g]),
            .bit_o (step_bit[g])
        );
        // quotient bit enters the freed LSB of the dividend half
        assign chain[g+1] = {step_acc[g][AW-1:1], step_acc[g][0] | step_bit[g]};
    end

    // ---------------- exit fixup ----------------
    logic [AW-1:0]   prod;
    logic [XLEN-1:0] quo, rmd, fix_res;

    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
        rmd  = neg_q ? -acc_q[AW-1:XLEN] : acc_q[AW-1:XLEN];
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[AW-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quo;
            default:                       fix_res = rmd;
        endcase
        if (spec_q) fix_res = spec_val_q;
    end

    // ---------------- sequencer ----------------
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        fin_d      = fin_q;
        acc_d      = acc_q;
        opd_d      = opd_q;
        op_d       = op_q;
        neg_d      = neg_q;
        spec_d     = spec_q;
        spec_val_d = spec_val_q;
        rsp_data_d = rsp_data_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        state_d = ST_CALC;
                        cnt_d   = CW'(ITER - 1);
                        fin_d   = 1'b0;
                        op_d    = req_op;
                        if (is_div(req_op)) begin
                            acc_d = {{XLEN{1'b0}}, mag_a};
                            opd_d = mag_b;
                        end else begin
                            acc_d = {{XLEN{1'b0}}, mag_b};
                            opd_d = mag_a;
                        end
                        neg_d      = is_rem(req_op) ? sgn_a : (sgn_a ^ sgn_b);
                        spec_d     = is_div(req_op) && (div0 || ovf);
                        spec_val_d = div0 ? (is_rem(req_op) ? req_rs1_i : {XLEN{1'b1}})
                                          : (is_rem(req_op) ? {XLEN{1'b0}} : req_rs1_i);
                    end
                end
                ST_CALC: begin
                    if (fin_q) begin
                        // accumulator is final; negation/select kept off the iteration path
                        rsp_data_d = fix_res;
                        state_d    = ST_DONE;
                    end else begin
                        acc_d = chain[UNROLL];
                        cnt_d = cnt_q - CW'(1);
                        fin_d = (cnt_q == '0);
                    end
                end
                ST_DONE: begin
                    if (rsp_ready_i) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            fin_q      <= 1'b0;
            acc_q      <= '0;
            opd_q      <= '0;
            op_q       <= OP_MUL;
            neg_q      <= 1'b0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            rsp_data_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            fin_q      <= fin_d;
            acc_q      <= acc_d;
            opd_q      <= opd_d;
            op_q       <= op_d;
            neg_q      <= neg_d;
            spec_q     <= spec_d;
            spec_val_q <= spec_val_d;
            rsp_data_q <= rsp_data_d;
        end
    end

    assign req_ready_o = (state_q == ST_IDLE);
    assign rsp_valid_o = (state_q == ST_DONE);
    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_data_o  = rsp_data_q;

endmodule
